// File: rtl/serial_multi_reg_loader.sv
// serial_multi_reg_loader: framed serial loader into NCH parallel channel registers.
// Frame (MSB first): start bit 0, ADDR_W address bits, DATA_W data bits,
// then one even-parity bit when SERIAL_LOADER_PARITY_EN is defined.
// The commit happens on the edge that samples the last frame bit; done/err
// pulse in the following cycle.
//
// state | meaning
// IDLE  | line idle, waiting for a start bit (0)
// ADDR  | shifting in the channel address
// DATA  | shifting in the data word
// PAR   | sampling the parity bit (SERIAL_LOADER_PARITY_EN only)
module serial_multi_reg_loader #(
   parameter int DATA_W = 4,
   parameter int NCH    = 4,
   localparam int ADDR_W = $clog2(NCH)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    serIn,
   input  logic                    Zero,
   output logic [NCH*DATA_W-1:0]   Lout,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [ADDR_W-1:0]       last_addr
);

   localparam int MAXB  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
   localparam int CNT_W = $clog2(MAXB) + 1;
   localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W:0]   NCH_L     = (ADDR_W + 1)'(NCH);

`ifdef SERIAL_LOADER_PARITY_EN
   typedef enum logic [1:0] {IDLE, ADDR, DATA, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [ADDR_W-1:0]   addr_sr, addr_nxt;
   logic [DATA_W-1:0]   data_sr, data_nxt;
   logic [ADDR_W:0]     addr_shift;
   logic [DATA_W:0]     data_shift;
   logic [DATA_W-1:0]   commit_word;
   logic                commit_ok, commit_bad, addr_ok;

   // the address is complete once the FSM reaches DATA, so it can be range-checked directly
   assign addr_shift = {addr_sr, serIn};
   assign data_shift = {data_sr, serIn};
   assign addr_ok    = ({1'b0, addr_sr} < NCH_L);
   assign busy       = (state != IDLE);

   // next-state, shift and commit decode
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      addr_nxt    = addr_sr;
      data_nxt    = data_sr;
      commit_word = data_shift[DATA_W-1:0];
      commit_ok   = 1'b0;
      commit_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!serIn) begin
               state_nxt = ADDR;
               cnt_nxt   = '0;
            end
         end
         ADDR: begin
            addr_nxt = addr_shift[ADDR_W-1:0];
            if (cnt == ADDR_LAST) begin
               state_nxt = DATA;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            data_nxt = data_shift[DATA_W-1:0];
            if (cnt == DATA_LAST) begin
               cnt_nxt = '0;
`ifdef SERIAL_LOADER_PARITY_EN
               state_nxt = PAR;
`else
               state_nxt  = IDLE;
               commit_ok  = addr_ok;
               commit_bad = !addr_ok;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`ifdef SERIAL_LOADER_PARITY_EN
         PAR: begin
            state_nxt   = IDLE;
            commit_word = data_sr;
            commit_ok   = addr_ok && !((^addr_sr) ^ (^data_sr) ^ serIn);
            commit_bad  = !commit_ok;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // bit counter and shift registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt     <= '0;
         addr_sr <= '0;
         data_sr <= '0;
      end else begin
         cnt     <= cnt_nxt;
         addr_sr <= addr_nxt;
         data_sr <= data_nxt;
      end
   end

   // channel registers; Zero wins over a same-edge commit but done still reports it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Lout <= '0;
      end else if (Zero) begin
         Lout <= '0;
      end else if (commit_ok) begin
         for (int i = 0; i < NCH; i++) begin
            if (addr_sr == ADDR_W'(i)) Lout[i*DATA_W +: DATA_W] <= commit_word;
         end
      end
   end

   // status pulses and last committed address
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         done      <= 1'b0;
         err       <= 1'b0;
         last_addr <= '0;
      end else begin
         done <= commit_ok;
         err  <= commit_bad;
         if (commit_ok) last_addr <= addr_sr;
      end
   end

endmodule

// File: tb/tb_serial_multi_reg_loader.sv
// Directed bench for serial_multi_reg_loader at DATA_W=4, NCH=4.
// Honours SERIAL_LOADER_PARITY_EN: frames gain a parity bit and the parity test runs.
module tb_serial_multi_reg_loader;

`ifdef SERIAL_LOADER_PARITY_EN
   localparam int FLEN = 8;
`else
   localparam int FLEN = 7;
`endif

   logic        CLK = 1'b0;
   logic        RST, serIn, Zero;
   logic [15:0] Lout;
   logic        busy, done, err;
   logic [1:0]  last_addr;
   int          checks = 0;
   int          errors = 0;

   serial_multi_reg_loader #(.DATA_W(4), .NCH(4)) dut (
      .CLK(CLK), .RST(RST), .serIn(serIn), .Zero(Zero), .Lout(Lout),
      .busy(busy), .done(done), .err(err), .last_addr(last_addr)
   );

   always #5 CLK = ~CLK;

   // frame bits right-aligned, sent from bit FLEN-1 down to 0
   function automatic logic [7:0] make_frame(input logic [1:0] a, input logic [3:0] d);
      logic [7:0] f;
`ifdef SERIAL_LOADER_PARITY_EN
      f = {1'b0, a, d, ^{a, d}};
`else
      f = {2'b00, a, d};
`endif
      return f;
   endfunction

   task automatic frame_bit(input logic b);
      serIn = b;
      @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [1:0] a, input logic [3:0] d);
      logic [7:0] f;
      f = make_frame(a, d);
      for (int i = FLEN - 1; i >= 0; i--) frame_bit(f[i]);
   endtask

   task automatic test_reset;
      RST = 1'b1; serIn = 1'b1; Zero = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (Lout !== 16'h0) begin errors++; $display("FAIL reset_lout got %h exp 0000", Lout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      checks++; if (last_addr !== 2'd0) begin errors++; $display("FAIL reset_last_addr got %0d exp 0", last_addr); end
      RST = 1'b0;
      for (int c = 0; c < 10; c++) begin
         frame_bit(1'b1);
         checks++;
         if ({Lout, busy, done, err} !== 19'h0) begin
            errors++;
            $display("FAIL idle cycle %0d got lout=%h busy=%b done=%b err=%b exp all 0", c, Lout, busy, done, err);
         end
      end
   endtask

   task automatic test_single_write;
      logic [7:0] f;
      f = make_frame(2'd2, 4'hB);
      for (int k = 1; k <= FLEN; k++) begin
         frame_bit(f[FLEN-k]);
         if (k == 1) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_start got %b exp 1", busy); end
         end
         if (k == FLEN - 1) begin
            checks++;
            if (Lout !== 16'h0 || done !== 1'b0) begin
               errors++; $display("FAIL single_early got lout=%h done=%b exp 0000/0", Lout, done);
            end
         end
      end
      checks++; if (Lout !== 16'h0B00) begin errors++; $display("FAIL single_lout got %h exp 0b00", Lout); end
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL single_done got done=%b err=%b exp 1/0", done, err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
      checks++; if (last_addr !== 2'd2) begin errors++; $display("FAIL single_last_addr got %0d exp 2", last_addr); end
      frame_bit(1'b1);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", done); end
   endtask

   task automatic test_zero_clear;
      Zero = 1'b1;
      frame_bit(1'b1);
      Zero = 1'b0;
      checks++; if (Lout !== 16'h0) begin errors++; $display("FAIL zero_clear got %h exp 0000", Lout); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_no_done got %b exp 0", done); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] f2;
      logic [7:0]  fa, fb;
      fa = make_frame(2'd0, 4'h3);
      fb = make_frame(2'd3, 4'hC);
      for (int k = 1; k <= 2 * FLEN; k++) begin
         frame_bit(k <= FLEN ? fa[FLEN-k] : fb[2*FLEN-k]);
         checks++;
         if (done !== ((k == FLEN) || (k == 2 * FLEN))) begin
            errors++; $display("FAIL b2b_done bit %0d got %b", k, done);
         end
         if (k == FLEN) begin
            checks++; if (Lout !== 16'h0003) begin errors++; $display("FAIL b2b_first got %h exp 0003", Lout); end
         end
      end
      f2 = Lout;
      checks++; if (f2 !== 16'hC003) begin errors++; $display("FAIL b2b_lout got %h exp c003", f2); end
      checks++; if (last_addr !== 2'd3) begin errors++; $display("FAIL b2b_last_addr got %0d exp 3", last_addr); end
      frame_bit(1'b1);
   endtask

   task automatic test_zero_collision;
      logic [7:0] f;
      Zero = 1'b1; frame_bit(1'b1); Zero = 1'b0;
      send_frame(2'd2, 4'h9);
      checks++; if (Lout !== 16'h0900) begin errors++; $display("FAIL coll_preload got %h exp 0900", Lout); end
      f = make_frame(2'd1, 4'h6);
      for (int k = 1; k <= FLEN; k++) begin
         if (k == FLEN) Zero = 1'b1;
         frame_bit(f[FLEN-k]);
      end
      Zero = 1'b0;
      checks++; if (Lout !== 16'h0) begin errors++; $display("FAIL coll_lout got %h exp 0000", Lout); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL coll_done got %b exp 1", done); end
      checks++; if (last_addr !== 2'd1) begin errors++; $display("FAIL coll_last_addr got %0d exp 1", last_addr); end
      frame_bit(1'b1);
   endtask

   task automatic test_zero_midframe;
      logic [7:0] f;
      send_frame(2'd0, 4'hF);
      checks++; if (Lout !== 16'h000F) begin errors++; $display("FAIL mid_preload got %h exp 000f", Lout); end
      f = make_frame(2'd3, 4'h5);
      for (int k = 1; k <= FLEN; k++) begin
         Zero = (k == 3);
         frame_bit(f[FLEN-k]);
         if (k == 3) begin
            checks++;
            if (Lout !== 16'h0 || busy !== 1'b1) begin
               errors++; $display("FAIL mid_zero got lout=%h busy=%b exp 0000/1", Lout, busy);
            end
         end
      end
      Zero = 1'b0;
      checks++; if (Lout !== 16'h5000) begin errors++; $display("FAIL mid_lout got %h exp 5000", Lout); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_done got %b exp 1", done); end
      frame_bit(1'b1);
   endtask

   task automatic test_reset_midframe;
      logic [7:0] f;
      f = make_frame(2'd1, 4'h5);
      for (int k = 1; k <= 3; k++) frame_bit(f[FLEN-k]);
      RST = 1'b1;
      #1;
      checks++; if (Lout !== 16'h0) begin errors++; $display("FAIL rstmid_lout got %h exp 0000", Lout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      checks++; if (last_addr !== 2'd0) begin errors++; $display("FAIL rstmid_last_addr got %0d exp 0", last_addr); end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      serIn = 1'b1;
      send_frame(2'd1, 4'h5);
      checks++; if (Lout !== 16'h0050) begin errors++; $display("FAIL rstmid_resend got %h exp 0050", Lout); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b exp 1", done); end
      checks++; if (last_addr !== 2'd1) begin errors++; $display("FAIL rstmid_last_addr2 got %0d exp 1", last_addr); end
      frame_bit(1'b1);
   endtask

`ifdef SERIAL_LOADER_PARITY_EN
   task automatic test_parity;
      logic [7:0] f;
      Zero = 1'b1; frame_bit(1'b1); Zero = 1'b0;
      send_frame(2'd1, 4'hA);
      checks++; if (Lout !== 16'h00A0) begin errors++; $display("FAIL par_good got %h exp 00a0", Lout); end
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL par_good_done got done=%b err=%b exp 1/0", done, err); end
      f = make_frame(2'd1, 4'hA) ^ 8'h01;
      for (int i = FLEN - 1; i >= 0; i--) frame_bit(f[i]);
      checks++; if (Lout !== 16'h00A0) begin errors++; $display("FAIL par_bad_lout got %h exp 00a0", Lout); end
      checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL par_bad_err got err=%b done=%b exp 1/0", err, done); end
      send_frame(2'd2, 4'h7);
      f = make_frame(2'd3, 4'hA) ^ 8'h01;
      for (int i = FLEN - 1; i >= 0; i--) frame_bit(f[i]);
      checks++; if (Lout !== 16'h07A0) begin errors++; $display("FAIL par_bad3_lout got %h exp 07a0", Lout); end
      checks++; if (last_addr !== 2'd2 || err !== 1'b1) begin errors++; $display("FAIL par_bad3_status got addr=%0d err=%b exp 2/1", last_addr, err); end
      frame_bit(1'b1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL par_err_width got %b exp 0", err); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_zero_clear();
      test_back_to_back();
      test_zero_collision();
      test_zero_midframe();
      test_reset_midframe();
`ifdef SERIAL_LOADER_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
